// File: rtl/operand_select_pipe_pkg.sv
// Shared definitions for the operand selector: handshake state encoding and
// the select-width helper used by both the top and the per-port lane.
package operand_select_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  // Select field width for n sources; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/operand_select_lane.sv
// One read port: picks a source word by select, applies write-back
// forwarding, and flags selects that point past the last source.
module operand_select_lane
  import operand_select_pipe_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 8,
  localparam int SEL_W  = sel_width(NUM_SRC)
) (
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     fwd_en,
  input  logic [SEL_W-1:0]         fwd_sel,
  input  logic [WIDTH-1:0]         fwd_data,
  output logic [WIDTH-1:0]         data,
  output logic                     err
);

  logic             in_range;
  logic [WIDTH-1:0] picked;

  // Explicit compare-per-source mux so an out-of-range select never indexes
  // past src_data; forwarding only wins for in-range indices.
  always_comb begin
    in_range = 1'b0;
    picked   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        in_range = 1'b1;
        picked   = src_data[k*WIDTH +: WIDTH];
      end
    end
    if (in_range && fwd_en && (fwd_sel == sel)) data = fwd_data;
    else                                        data = picked;
    err = ~in_range;
  end

endmodule

// File: rtl/operand_select_pipe.sv
// Registered N-to-M operand selector with a valid/ready handshake and a
// 2-entry skid buffer (output register + skid register).
module operand_select_pipe
  import operand_select_pipe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_SRC   = 8,
  parameter int NUM_PORTS = 2,
  localparam int SEL_W    = sel_width(NUM_SRC)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*WIDTH-1:0]   src_data,
  input  logic [NUM_PORTS*SEL_W-1:0] sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       fwd_en,
  input  logic [SEL_W-1:0]           fwd_sel,
  input  logic [WIDTH-1:0]           fwd_data,
  output logic [NUM_PORTS*WIDTH-1:0] out_data,
  output logic [NUM_PORTS-1:0]       out_err,
  output logic                       out_valid,
  input  logic                       out_ready
);

  logic [NUM_PORTS*WIDTH-1:0] req_data;
  logic [NUM_PORTS-1:0]       req_err;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    operand_select_lane #(
      .WIDTH   (WIDTH),
      .NUM_SRC (NUM_SRC)
    ) u_lane (
      .src_data (src_data),
      .sel      (sel[p*SEL_W +: SEL_W]),
      .fwd_en   (fwd_en),
      .fwd_sel  (fwd_sel),
      .fwd_data (fwd_data),
      .data     (req_data[p*WIDTH +: WIDTH]),
      .err      (req_err[p])
    );
  end

  state_e                     state_q, state_d;
  logic [NUM_PORTS*WIDTH-1:0] or_data_q, or_data_d;
  logic [NUM_PORTS-1:0]       or_err_q, or_err_d;
  logic                       or_vld_q, or_vld_d;
  logic [NUM_PORTS*WIDTH-1:0] sr_data_q, sr_data_d;
  logic [NUM_PORTS-1:0]       sr_err_q, sr_err_d;
  logic                       sr_vld_q, sr_vld_d;

  logic accept, consume;

  // in_ready comes from registered state only, never from out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = or_vld_q;
  assign out_data  = or_data_q;
  assign out_err   = or_err_q;

  assign accept  = in_valid && in_ready;
  assign consume = or_vld_q && out_ready;

  // Next-state and buffer-load decisions for the skid handshake.
  always_comb begin
    state_d   = state_q;
    or_data_d = or_data_q;
    or_err_d  = or_err_q;
    or_vld_d  = or_vld_q;
    sr_data_d = sr_data_q;
    sr_err_d  = sr_err_q;
    sr_vld_d  = sr_vld_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          or_data_d = req_data;
          or_err_d  = req_err;
          or_vld_d  = 1'b1;
          state_d   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          or_data_d = req_data;
          or_err_d  = req_err;
        end else if (consume) begin
          or_vld_d = 1'b0;
          state_d  = ST_EMPTY;
        end else if (accept) begin
          sr_data_d = req_data;
          sr_err_d  = req_err;
          sr_vld_d  = 1'b1;
          state_d   = ST_TWO;
        end
      end
      ST_TWO: begin
        if (consume) begin
          or_data_d = sr_data_q;
          or_err_d  = sr_err_q;
          or_vld_d  = sr_vld_q;
          sr_vld_d  = 1'b0;
          state_d   = ST_ONE;
        end
      end
      default: begin
        or_vld_d = 1'b0;
        sr_vld_d = 1'b0;
        state_d  = ST_EMPTY;
      end
    endcase
  end

  // State and buffer registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      or_data_q <= '0;
      or_err_q  <= '0;
      or_vld_q  <= 1'b0;
      sr_data_q <= '0;
      sr_err_q  <= '0;
      sr_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      or_data_q <= or_data_d;
      or_err_q  <= or_err_d;
      or_vld_q  <= or_vld_d;
      sr_data_q <= sr_data_d;
      sr_err_q  <= sr_err_d;
      sr_vld_q  <= sr_vld_d;
    end
  end

endmodule

// File: tb/tb_operand_select_pipe.sv
// Directed bench for operand_select_pipe with NUM_SRC = 6 (3-bit selects,
// indices 6 and 7 out of range).
module tb_operand_select_pipe;

  localparam int WIDTH = 16;
  localparam int NSRC  = 6;
  localparam int NP    = 2;
  localparam int SW    = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [NP*SW-1:0]      sel;
  logic                  in_valid;
  logic                  in_ready;
  logic                  fwd_en;
  logic [SW-1:0]         fwd_sel;
  logic [WIDTH-1:0]      fwd_data;
  logic [NP*WIDTH-1:0]   out_data;
  logic [NP-1:0]         out_err;
  logic                  out_valid;
  logic                  out_ready;

  int n_assert = 0;
  int n_fail   = 0;

  operand_select_pipe #(
    .WIDTH     (WIDTH),
    .NUM_SRC   (NSRC),
    .NUM_PORTS (NP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_data  (src_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fwd_en    (fwd_en),
    .fwd_sel   (fwd_sel),
    .fwd_data  (fwd_data),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] src_word(input int s);
    return (s < NSRC) ? WIDTH'(16'h1000 + s) : '0;
  endfunction

  task automatic load_src();
    for (int k = 0; k < NSRC; k++) src_data[k*WIDTH +: WIDTH] = WIDTH'(16'h1000 + k);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fwd_en    = 1'b0;
    fwd_sel   = '0;
    fwd_data  = '0;
    sel       = '0;
    load_src();
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_err",   64'(out_err),   64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // Basic select: port0 <- src0, port1 <- src5
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sel       = {3'd5, 3'd0};
    step();
    chk("basic_valid", 64'(out_valid), 64'd1);
    chk("basic_data",  64'(out_data),  64'h1005_1000);
    chk("basic_err",   64'(out_err),   64'd0);

    // Forwarding overrides src5 on port1
    fwd_en   = 1'b1;
    fwd_sel  = 3'd5;
    fwd_data = 16'hBEEF;
    step();
    chk("fwd_data", 64'(out_data), 64'hBEEF_1000);
    chk("fwd_err",  64'(out_err),  64'd0);

    // Out-of-range select 7 on port0; forward to 7 must not match
    sel     = {3'd2, 3'd7};
    fwd_sel = 3'd7;
    step();
    chk("oor_data", 64'(out_data), 64'h1002_0000);
    chk("oor_err",  64'(out_err),  64'b01);

    // Drain
    in_valid = 1'b0;
    fwd_en   = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Stall: accept A then B with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = {3'd1, 3'd0};
    step();
    chk("stallA_data",  64'(out_data), 64'h1001_1000);
    chk("stallA_ready", 64'(in_ready), 64'd1);
    sel = {3'd3, 3'd2};
    step();
    chk("stallB_ready", 64'(in_ready), 64'd0);
    chk("stallB_hold",  64'(out_data), 64'h1001_1000);
    // Third request C is held off; source changes must not leak in
    sel      = {3'd5, 3'd4};
    src_data = {NSRC{16'hDEAD}};
    step();
    chk("stallC_ready", 64'(in_ready),  64'd0);
    chk("stallC_hold",  64'(out_data),  64'h1001_1000);
    chk("stallC_valid", 64'(out_valid), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("popB_data",  64'(out_data),  64'h1003_1002);
    chk("popB_valid", 64'(out_valid), 64'd1);
    chk("popB_ready", 64'(in_ready),  64'd1);
    step();
    chk("popEnd_valid", 64'(out_valid), 64'd0);
    load_src();

    // Streaming: 20 back-to-back requests, each visible one cycle later
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sel = {SW'((i + 3) % 8), SW'(i % 8)};
      step();
      chk($sformatf("strm%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("strm%0d_data", i), 64'(out_data),
          64'({src_word((i + 3) % 8), src_word(i % 8)}));
      chk($sformatf("strm%0d_err", i), 64'(out_err),
          64'({1'((i + 3) % 8 >= NSRC), 1'(i % 8 >= NSRC)}));
      chk($sformatf("strm%0d_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_end_valid", 64'(out_valid), 64'd0);

    // Fill to TWO, then assert reset asynchronously mid-cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = {3'd4, 3'd3};
    step();
    step();
    in_valid = 1'b0;
    chk("two_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data",  64'(out_data),  64'd0);
    chk("arst_err",   64'(out_err),   64'd0);
    chk("arst_ready", 64'(in_ready),  64'd1);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    // Skid register must have been cleared: one accept yields exactly one output
    in_valid = 1'b1;
    sel      = {3'd0, 3'd1};
    step();
    in_valid = 1'b0;
    chk("post_rst_data", 64'(out_data), 64'h1000_1001);
    step();
    chk("post_rst_nodup", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
